// File: rtl/intr_system_pkg.sv
// Shared constants and types for the interrupt arbiter: SPR numbers, exception
// codes, one-hot source IDs and FSM states.
package intr_system_pkg;

  localparam int ExcepCode_WIDTH = 5;
  localparam int MSR_EE          = 16;

  localparam logic [9:0] SPRN_ESR    = 10'd62;
  localparam logic [9:0] SPRN_IVPR   = 10'd63;
  localparam logic [9:0] SPRN_IVOR0  = 10'd400, SPRN_IVOR1  = 10'd401;
  localparam logic [9:0] SPRN_IVOR2  = 10'd402, SPRN_IVOR3  = 10'd403;
  localparam logic [9:0] SPRN_IVOR4  = 10'd404, SPRN_IVOR5  = 10'd405;
  localparam logic [9:0] SPRN_IVOR6  = 10'd406, SPRN_IVOR7  = 10'd407;
  localparam logic [9:0] SPRN_IVOR8  = 10'd408, SPRN_IVOR9  = 10'd409;
  localparam logic [9:0] SPRN_IVOR10 = 10'd410, SPRN_IVOR11 = 10'd411;
  localparam logic [9:0] SPRN_IVOR12 = 10'd412, SPRN_IVOR13 = 10'd413;
  localparam logic [9:0] SPRN_IVOR14 = 10'd414, SPRN_IVOR15 = 10'd415;

  // {valid, IVOR index}
  localparam logic [4:0] EXC_NONE = 5'h00;
  localparam logic [4:0] EXC_DSI  = 5'h12;
  localparam logic [4:0] EXC_ISI  = 5'h13;
  localparam logic [4:0] EXC_EXT  = 5'h14;
  localparam logic [4:0] EXC_PROG = 5'h16;
  localparam logic [4:0] EXC_SC   = 5'h18;
  localparam logic [4:0] EXC_DTLB = 5'h1D;
  localparam logic [4:0] EXC_ITLB = 5'h1E;

  typedef enum logic [7:0] {
    SRC_NONE = 8'h00,
    SRC_ITLB = 8'h01,
    SRC_ISI  = 8'h02,
    SRC_PROG = 8'h04,
    SRC_SC   = 8'h08,
    SRC_DTLB = 8'h10,
    SRC_DSI  = 8'h20,
    SRC_DEV0 = 8'h40,
    SRC_DEV1 = 8'h80
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACKD = 2'd2
  } intr_state_e;

  function automatic logic [4:0] src_code(input src_e s);
    case (s)
      SRC_ITLB:           return EXC_ITLB;
      SRC_ISI:            return EXC_ISI;
      SRC_PROG:           return EXC_PROG;
      SRC_SC:             return EXC_SC;
      SRC_DTLB:           return EXC_DTLB;
      SRC_DSI:            return EXC_DSI;
      SRC_DEV0, SRC_DEV1: return EXC_EXT;
      default:            return EXC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/intr_spr_file.sv
// Three-port IVOR0..15 / IVPR / ESR register file with a hardware ESR capture
// port; reads are combinational, writes land on the rising edge.
module intr_spr_file
  import intr_system_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  addr0,
  input  logic [9:0]  addr1,
  input  logic [9:0]  addr2,
  input  logic [0:31] wd0,
  input  logic [0:31] wd1,
  input  logic [0:31] wd2,
  input  logic        wr0,
  input  logic        wr1,
  input  logic        wr2,
  output logic [31:0] rd0,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic [3:0]  ivor_sel,
  output logic [0:31] ivor_sel_q,
  output logic [0:31] ivpr_q,
  input  logic        esr_cap,
  input  logic [2:0]  esr_cause
);

  logic [0:31] ivor [16];
  logic [0:31] ivpr;
  logic [0:31] esr;

  logic [9:0]  pa [3];
  logic [0:31] pd [3];
  logic [2:0]  pw;
  logic [0:31] prd [3];
  logic [3:0]  pidx [3];
  logic [2:0]  hit_ivor;
  logic [2:0]  hit_ivpr;
  logic [2:0]  hit_esr;

  assign pa[0] = addr0;
  assign pa[1] = addr1;
  assign pa[2] = addr2;
  assign pd[0] = wd0;
  assign pd[1] = wd1;
  assign pd[2] = wd2;
  assign pw    = {wr2, wr1, wr0};

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      hit_ivor[p] = (pa[p] >= SPRN_IVOR0) && (pa[p] <= SPRN_IVOR15);
      hit_ivpr[p] = (pa[p] == SPRN_IVPR);
      hit_esr[p]  = (pa[p] == SPRN_ESR);
      pidx[p]     = 4'(pa[p] - SPRN_IVOR0);
      if (hit_ivor[p])      prd[p] = ivor[pidx[p]];
      else if (hit_ivpr[p]) prd[p] = ivpr;
      else if (hit_esr[p])  prd[p] = esr;
      else                  prd[p] = '0;
    end
  end

  assign rd0        = prd[0];
  assign rd1        = prd[1];
  assign rd2        = prd[2];
  assign ivor_sel_q = ivor[ivor_sel];
  assign ivpr_q     = ivpr;

  // Ports are applied in ascending order so the highest port wins a clash,
  // and the ESR capture comes last so it overrides any software write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) ivor[i] <= '0;
      ivpr <= '0;
      esr  <= '0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (pw[p]) begin
          if (hit_ivor[p])      ivor[pidx[p]] <= pd[p];
          else if (hit_ivpr[p]) ivpr          <= pd[p];
          else if (hit_esr[p])  esr           <= pd[p];
        end
      end
      if (esr_cap) esr <= {4'b0000, esr_cause, 25'd0};
    end
  end

endmodule

// File: rtl/intr_system.sv
// Interrupt arbiter: picks the highest-priority eligible request, presents its
// code and vector to the CU, and pulses the source's ack once the CU accepts.
module intr_system #(
  parameter int ExcepCode_WIDTH = intr_system_pkg::ExcepCode_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [9:0]                  addr0,
  input  logic [9:0]                  addr1,
  input  logic [9:0]                  addr2,
  input  logic [0:31]                 wd0,
  input  logic [0:31]                 wd1,
  input  logic [0:31]                 wd2,
  input  logic                        wr0,
  input  logic                        wr1,
  input  logic                        wr2,
  output logic [31:0]                 rd0,
  output logic [31:0]                 rd1,
  output logic [31:0]                 rd2,
  input  logic                        DSI_req,
  input  logic                        ISI_req,
  input  logic                        ITLB_req,
  input  logic                        DTLB_req,
  input  logic                        DEV0_req,
  input  logic                        DEV1_req,
  input  logic                        progErr_req,
  input  logic                        SC_req,
  output logic                        DSI_ack,
  output logic                        ISI_ack,
  output logic                        ITLB_ack,
  output logic                        DTLB_ack,
  output logic                        DEV0_ack,
  output logic                        DEV1_ack,
  output logic                        progErr_ack,
  output logic                        SC_ack,
  input  logic                        ack,
  input  logic [0:31]                 MSR,
  input  logic [2:0]                  progErrCode,
  output logic [ExcepCode_WIDTH-1:0]  excepCode,
  output logic [31:0]                 intrEntryAddr,
  output intr_system_pkg::intr_state_e state_dbg
);

  import intr_system_pkg::*;

  // Handshake: a source holds *_req until it sees its one-cycle *_ack; the CU
  // pulses ack while excepCode is non-zero, and the ack pulse follows one cycle later.

  intr_state_e state, state_nxt;
  src_e        src_q, src_nxt, winner;
  logic [7:0]  ack_q, ack_nxt;
  logic [4:0]  sel_code;
  logic [ExcepCode_WIDTH-1:0] code_nxt;
  logic [31:0] addr_nxt;
  logic [0:31] ivor_sel_q;
  logic [0:31] ivpr_q;
  logic        ee;
  logic        esr_cap;
  logic        unused_bits;

  intr_spr_file u_spr (
    .clk        (clk),
    .rst        (rst),
    .addr0      (addr0),
    .addr1      (addr1),
    .addr2      (addr2),
    .wd0        (wd0),
    .wd1        (wd1),
    .wd2        (wd2),
    .wr0        (wr0),
    .wr1        (wr1),
    .wr2        (wr2),
    .rd0        (rd0),
    .rd1        (rd1),
    .rd2        (rd2),
    .ivor_sel   (sel_code[3:0]),
    .ivor_sel_q (ivor_sel_q),
    .ivpr_q     (ivpr_q),
    .esr_cap    (esr_cap),
    .esr_cause  (progErrCode)
  );

  assign ee = MSR[MSR_EE];

  always_comb begin
    winner = SRC_NONE;
    if (ITLB_req)              winner = SRC_ITLB;
    else if (ISI_req)          winner = SRC_ISI;
    else if (progErr_req)      winner = SRC_PROG;
    else if (SC_req)           winner = SRC_SC;
    else if (DTLB_req)         winner = SRC_DTLB;
    else if (DSI_req)          winner = SRC_DSI;
    else if (DEV0_req && ee)   winner = SRC_DEV0;
    else if (DEV1_req && ee)   winner = SRC_DEV1;
  end

  always_comb begin
    state_nxt = state;
    src_nxt   = src_q;
    ack_nxt   = '0;
    case (state)
      ST_IDLE: if (winner != SRC_NONE) begin
        state_nxt = ST_PEND;
        src_nxt   = winner;
      end
      ST_PEND: if (ack) begin
        state_nxt = ST_ACKD;
        ack_nxt   = src_q;
      end
      ST_ACKD: begin
        state_nxt = ST_IDLE;
        src_nxt   = SRC_NONE;
      end
      default: begin
        state_nxt = ST_IDLE;
        src_nxt   = SRC_NONE;
      end
    endcase
  end

  // Outputs are registered from the next-state view so they are valid in the
  // first PEND cycle and keep tracking live SPR contents while pending.
  assign sel_code = (state_nxt == ST_PEND) ? src_code(src_nxt) : EXC_NONE;
  assign code_nxt = ExcepCode_WIDTH'(sel_code);
  assign addr_nxt = (state_nxt == ST_PEND) ?
                    {ivpr_q[0:15], ivor_sel_q[16:27], 4'b0000} : '0;
  assign esr_cap  = (state == ST_IDLE) && (winner == SRC_PROG);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      src_q         <= SRC_NONE;
      ack_q         <= '0;
      excepCode     <= '0;
      intrEntryAddr <= '0;
    end else begin
      state         <= state_nxt;
      src_q         <= src_nxt;
      ack_q         <= ack_nxt;
      excepCode     <= code_nxt;
      intrEntryAddr <= addr_nxt;
    end
  end

  assign ITLB_ack    = ack_q[0];
  assign ISI_ack     = ack_q[1];
  assign progErr_ack = ack_q[2];
  assign SC_ack      = ack_q[3];
  assign DTLB_ack    = ack_q[4];
  assign DSI_ack     = ack_q[5];
  assign DEV0_ack    = ack_q[6];
  assign DEV1_ack    = ack_q[7];
  assign state_dbg   = state;

  assign unused_bits = ^{MSR[0:15], MSR[17:31], ivor_sel_q[0:15],
                         ivor_sel_q[28:31], ivpr_q[16:31]};

endmodule

// File: tb/tb_intr_system.sv
// Randomized bench for intr_system: a reference model predicts each grant,
// and a monitor checks every ack pulse against the expected queue.
module tb_intr_system;
  import intr_system_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  addr0, addr1, addr2;
  logic [0:31] wd0, wd1, wd2;
  logic        wr0, wr1, wr2;
  logic [31:0] rd0, rd1, rd2;
  logic        DSI_req, ISI_req, ITLB_req, DTLB_req, DEV0_req, DEV1_req, progErr_req, SC_req;
  logic        DSI_ack, ISI_ack, ITLB_ack, DTLB_ack, DEV0_ack, DEV1_ack, progErr_ack, SC_ack;
  logic        ack;
  logic [0:31] MSR;
  logic [2:0]  progErrCode;
  logic [4:0]  excepCode;
  logic [31:0] intrEntryAddr;
  intr_state_e state_dbg;

  // Bench source index equals priority rank.
  localparam int P_ITLB = 0, P_ISI = 1, P_PROG = 2, P_SC = 3;
  localparam int P_DTLB = 4, P_DSI = 5, P_DEV0 = 6, P_DEV1 = 7;
  localparam int EXP_W = 45;

  logic [7:0] req_vec;
  logic [7:0] ack_vec;
  assign {DEV1_req, DEV0_req, DSI_req, DTLB_req, SC_req, progErr_req, ISI_req, ITLB_req} = req_vec;
  assign ack_vec = {DEV1_ack, DEV0_ack, DSI_ack, DTLB_ack, SC_ack, progErr_ack, ISI_ack, ITLB_ack};

  int n_cmp = 0;
  int n_bad = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [31:0] m_spr [1024];
  int ivor_of [8] = '{14, 3, 6, 8, 13, 2, 4, 4};

  always #5 clk = ~clk;

  intr_system dut (
    .clk(clk), .rst(rst),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wd0(wd0), .wd1(wd1), .wd2(wd2),
    .wr0(wr0), .wr1(wr1), .wr2(wr2),
    .rd0(rd0), .rd1(rd1), .rd2(rd2),
    .DSI_req(DSI_req), .ISI_req(ISI_req), .ITLB_req(ITLB_req), .DTLB_req(DTLB_req),
    .DEV0_req(DEV0_req), .DEV1_req(DEV1_req), .progErr_req(progErr_req), .SC_req(SC_req),
    .DSI_ack(DSI_ack), .ISI_ack(ISI_ack), .ITLB_ack(ITLB_ack), .DTLB_ack(DTLB_ack),
    .DEV0_ack(DEV0_ack), .DEV1_ack(DEV1_ack), .progErr_ack(progErr_ack), .SC_ack(SC_ack),
    .ack(ack), .MSR(MSR), .progErrCode(progErrCode),
    .excepCode(excepCode), .intrEntryAddr(intrEntryAddr), .state_dbg(state_dbg)
  );

  // ---------------- reference model ----------------
  function automatic bit mapped(input int a);
    return (a >= 400 && a <= 415) || a == 62 || a == 63;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    return mapped(a) ? m_spr[a] : 32'h0;
  endfunction

  function automatic int m_winner(input logic [7:0] held, input bit ee);
    for (int i = 0; i < 8; i++)
      if (held[i] && (i < P_DEV0 || ee)) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_vector(input int w);
    logic [31:0] ivpr, ivor;
    ivpr = m_spr[63];
    ivor = m_spr[400 + ivor_of[w]];
    return {ivpr[31:16], ivor[15:4], 4'h0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic spr_write3(input logic [2:0] en, input int a0, input int a1, input int a2,
                            input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    addr0 = 10'(a0); addr1 = 10'(a1); addr2 = 10'(a2);
    wd0 = d0; wd1 = d1; wd2 = d2;
    wr0 = en[0]; wr1 = en[1]; wr2 = en[2];
    @(negedge clk);
    wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
    if (en[0] && mapped(a0)) m_spr[a0] = d0;
    if (en[1] && mapped(a1)) m_spr[a1] = d1;
    if (en[2] && mapped(a2)) m_spr[a2] = d2;
  endtask

  task automatic spr_check(input int port, input int a, input string name);
    logic [31:0] got;
    case (port)
      0: addr0 = 10'(a);
      1: addr1 = 10'(a);
      default: addr2 = 10'(a);
    endcase
    #1;
    case (port)
      0: got = rd0;
      1: got = rd1;
      default: got = rd2;
    endcase
    check(name, got, m_read(a));
  endtask

  task automatic wait_pending(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (excepCode != 5'd0) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Presents a request set and retires every grant the model predicts, in order.
  task automatic serve(input logic [7:0] held_in, input logic [2:0] pcode, input bit esr_clash);
    logic [7:0] held;
    int w;
    bit ee, ok, seen;
    held = held_in;
    ee = (MSR & 32'h0000_8000) != 0;
    progErrCode = pcode;
    req_vec = held;
    if (esr_clash) begin
      addr2 = 10'd62; wd2 = 32'hFFFF_FFFF; wr2 = 1'b1;
      @(negedge clk);
      wr2 = 1'b0;
    end
    forever begin
      w = m_winner(held, ee);
      if (w < 0) break;
      if (w == P_PROG) m_spr[62] = 32'(pcode) << 25;
      exp_q.push_back({8'(1 << w), 5'(16 + ivor_of[w]), m_vector(w)});
      wait_pending(ok);
      if (!ok) begin
        n_cmp++; n_bad++;
        $display("FAIL grant_timeout: got no pending code want %h", 5'(16 + ivor_of[w]));
        exp_q.delete();
        req_vec = '0;
        repeat (3) @(negedge clk);
        return;
      end
      if (w == P_PROG) spr_check(0, 62, "esr_capture");
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      held[w] = 1'b0;
      req_vec = held;
      @(negedge clk);
    end
    if (held != 8'd0) begin
      seen = 1'b0;
      repeat (5) begin
        @(negedge clk);
        if (excepCode != 5'd0) seen = 1'b1;
      end
      check("masked_quiet", 32'(seen), 32'd0);
    end
    req_vec = '0;
    @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [4:0]  seen_code;
    logic [31:0] seen_addr;
    logic [7:0]  prev_ack;
    logic [EXP_W-1:0] e;
    seen_code = '0; seen_addr = '0; prev_ack = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        seen_code = '0; seen_addr = '0; prev_ack = '0;
      end else begin
        if (excepCode != 5'd0) begin
          seen_code = excepCode;
          seen_addr = intrEntryAddr;
        end
        if (ack_vec != 8'd0) begin
          check("ack_one_cycle", 32'(prev_ack), 32'd0);
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_ack: got %h want none", ack_vec);
          end else begin
            e = exp_q.pop_front();
            check("ack_source", 32'(ack_vec), 32'(e[44:37]));
            check("excep_code", 32'(seen_code), 32'(e[36:32]));
            check("entry_addr", seen_addr, e[31:0]);
          end
        end
        prev_ack = ack_vec;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    bit ok, seen;
    for (int i = 0; i < 1024; i++) m_spr[i] = '0;
    rst = 1'b0; ack = 1'b0; req_vec = '0; MSR = '0; progErrCode = '0;
    addr0 = '0; addr1 = '0; addr2 = '0; wd0 = '0; wd1 = '0; wd2 = '0;
    wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    check("rst_code", 32'(excepCode), 32'd0);
    check("rst_addr", intrEntryAddr, 32'd0);
    check("rst_acks", 32'(ack_vec), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    spr_check(0, 63, "rst_ivpr");
    spr_check(1, 62, "rst_esr");

    spr_write3(3'b111, 402, 403, 413, 32'h120, 32'h130, 32'h1D0);
    spr_check(0, 402, "ivor2_rd");
    spr_check(1, 403, "ivor3_rd");
    spr_check(2, 413, "ivor13_rd");
    check("ivor2_const", rd0, 32'h120);
    spr_check(0, 0, "sprn0_zero");
    spr_write3(3'b001, 100, 0, 0, 32'hDEAD_BEEF, 0, 0);
    spr_check(0, 100, "unmapped_rd");

    addr0 = 10'd402; wd0 = 32'h777; wr0 = 1'b1; addr1 = 10'd402;
    #1 check("rd_during_wr", rd1, 32'h120);
    @(negedge clk);
    wr0 = 1'b0; m_spr[402] = 32'h777;
    spr_check(1, 402, "rd_after_wr");

    spr_write3(3'b111, 404, 404, 404, 32'd1, 32'd2, 32'd3);
    spr_check(0, 404, "wr_conflict");
    check("wr_conflict_const", rd0, 32'd3);

    // ITLB vector and handshake
    spr_write3(3'b011, 63, 414, 0, 32'hFFF0_0000, 32'h1E0, 0);
    MSR = 32'h0;
    serve(8'(1 << P_ITLB), 3'b000, 1'b0);

    // External masking
    spr_write3(3'b001, 404, 0, 0, 32'h0000_0440, 0, 0);
    serve(8'(1 << P_DEV0), 3'b000, 1'b0);
    MSR = 32'h0000_C000;
    serve(8'(1 << P_DEV0), 3'b000, 1'b0);

    // Simultaneous requests
    spr_write3(3'b011, 408, 404, 0, 32'h0000_0ABC, 32'h0000_1230, 0);
    serve(8'((1 << P_ITLB) | (1 << P_SC) | (1 << P_DEV1)), 3'b000, 1'b0);

    // Program error, with and without a clashing software ESR write
    spr_write3(3'b011, 62, 406, 0, 32'hFFFF_FFFF, 32'h0000_0600, 0);
    serve(8'(1 << P_PROG), 3'b010, 1'b0);
    check("esr_prog_const", m_read(62), 32'h0400_0000);
    serve(8'(1 << P_PROG), 3'b101, 1'b1);
    spr_check(2, 62, "esr_after_clash");

    // Random SPR traffic
    for (int it = 0; it < 30; it++) begin
      int a[3];
      for (int p = 0; p < 3; p++) begin
        case ($urandom_range(0, 3))
          0: a[p] = 62;
          1: a[p] = 63;
          2: a[p] = 400 + $urandom_range(0, 15);
          default: a[p] = $urandom_range(0, 1023);
        endcase
      end
      spr_write3(3'($urandom_range(0, 7)), a[0], a[1], a[2], $urandom, $urandom, $urandom);
      spr_check(0, a[2], "rand_spr0");
      spr_check(1, 400 + $urandom_range(0, 15), "rand_spr1");
      spr_check(2, a[0], "rand_spr2");
    end

    // Random interrupt sessions
    for (int it = 0; it < 15; it++) begin
      spr_write3(3'b111, 63, 400 + $urandom_range(0, 15), 400 + $urandom_range(0, 15),
                 $urandom, $urandom, $urandom);
      MSR = $urandom;
      serve(8'($urandom_range(1, 255)), 3'($urandom_range(0, 7)), 1'b0);
    end

    // Reset in the middle of a pending program interrupt
    progErrCode = 3'b001;
    req_vec = 8'(1 << P_PROG);
    wait_pending(ok);
    check("rst_test_pending", 32'(ok), 32'd1);
    #2 rst = 1'b0;
    #1;
    for (int i = 0; i < 1024; i++) m_spr[i] = '0;
    check("midrst_code", 32'(excepCode), 32'd0);
    check("midrst_addr", intrEntryAddr, 32'd0);
    check("midrst_acks", 32'(ack_vec), 32'd0);
    spr_check(0, 63, "midrst_ivpr");
    spr_check(1, 62, "midrst_esr");
    repeat (2) @(negedge clk);
    req_vec = '0;
    rst = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (progErr_ack) seen = 1'b1;
    end
    check("no_ack_after_rst", 32'(seen), 32'd0);

    repeat (5) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/intr_system.md
Name: intr_system

Overview:
- Central interrupt arbiter of the PowerPC (Book E style) core.
- Holds the interrupt-vector SPRs: IVOR0..IVOR15, IVPR and ESR, behind three read/write SPR ports.
- Arbitrates eight level-held request lines: DSI, ISI, ITLB, DTLB, DEV0, DEV1, program error and system call. For the winning request it presents an exception code and vector address to the control unit (CU), then returns a one-cycle ack to the winning source once the CU acknowledges.
- The DSI and ISI checkers are separate blocks that feed DSI_req and ISI_req.

Parameters:
- ExcepCode_WIDTH, 5, width of excepCode. Encoding is {valid, IVOR index[3:0]}; 0 means none.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low; the port keeps the codebase name rst.
- addr0/addr1/addr2  in  10  SPR numbers for ports 0/1/2.
- wd0/wd1/wd2  in  32 [0:31]  SPR write data.
- wr0/wr1/wr2  in  1  SPR write enables.
- rd0/rd1/rd2  out  32  SPR read data.
- DSI_req, ISI_req, ITLB_req, DTLB_req, DEV0_req, DEV1_req, progErr_req, SC_req  in  1 each  interrupt requests, held by the source until its ack.
- DSI_ack, ISI_ack, ITLB_ack, DTLB_ack, DEV0_ack, DEV1_ack, progErr_ack, SC_ack  out  1 each  one-cycle grant-complete pulses.
- ack  in  1  CU acceptance pulse.
- MSR  in  32 [0:31]  current MSR; bit 16 is EE.
- progErrCode  in  3  program-error cause: [2] illegal, [1] privileged, [0] trap.
- excepCode  out  ExcepCode_WIDTH  pending exception code.
- intrEntryAddr  out  32  vector address of the pending exception.

Behaviour:
- SPR map:
  - IVOR0..15 = SPRN 400..415.
  - IVPR = 63.
  - ESR = 62.
  - Any other address reads 0 and writes to it are ignored.
- SPR reads: combinational on all three ports. A read during a write to the same SPR returns the old value.
- SPR writes: synchronous on the clk rising edge. On a same-address conflict, port 2 beats port 1, which beats port 0. All registers store the full 32 bits.
- Source mapping (IVOR index → excepCode):
  - DSI → IVOR2 (0x12).
  - ISI → IVOR3 (0x13).
  - DEV0 and DEV1 → IVOR4 (0x14).
  - progErr → IVOR6 (0x16).
  - SC → IVOR8 (0x18).
  - DTLB → IVOR13 (0x1D).
  - ITLB → IVOR14 (0x1E).
- Priority, highest first: ITLB, ISI, progErr, SC, DTLB, DSI, DEV0, DEV1.
- Masking: DEV0 and DEV1 are eligible only while MSR[16]=1. All other sources are unmaskable.
- State machine, three states:
  - IDLE: excepCode=0 and intrEntryAddr=0. If any eligible request is present at an edge, latch the winner's one-hot source ID and go to PEND.
  - PEND: excepCode and intrEntryAddr are registered outputs driven from the latched source. A new higher-priority request does not pre-empt. When ack=1 at an edge, assert the latched source's *_ack for exactly the next cycle and go to ACKD.
  - ACKD: *_ack is high for this cycle only; return to IDLE. Requests are not sampled in ACKD, so a source clearing its request on the ack edge is never re-granted.
- intrEntryAddr = {IVPR[0:15], IVOR[n][16:27], 4'b0000}. It is evaluated from live SPR contents while in PEND.
- ESR capture: on the edge that latches a program interrupt, ESR[4]=progErrCode[2], ESR[5]=progErrCode[1], ESR[6]=progErrCode[0], and all other ESR bits clear. This hardware update beats a same-edge SPR write to ESR.
- A request deasserted while in PEND still completes normally.
- Reset (rst=0, asynchronous): all SPRs cleared to 0, state IDLE, every *_ack=0, excepCode=0, intrEntryAddr=0. Reset mid-handshake abandons the pending exception without issuing an ack.

Decomposition:
- Shared package holds:
  - SPRN constants (SPRN_IVOR0..15, SPRN_IVPR, SPRN_ESR).
  - ExcepCode_WIDTH and the EXC_* code constants.
  - The source-ID one-hot enum.
  - The MSR_EE bit index (16).
- One sub-module, intr_spr_file: the three-port IVOR/IVPR/ESR register file with the hardware ESR-capture port.
- Arbiter and FSM stay in the top level.

Test Plan:
- Reset SPR readback: write IVOR2=0x120, IVOR3=0x130, IVOR13=0x1D0 in one cycle on ports 0/1/2 → next cycle rd0/rd1/rd2 return 0x120/0x130/0x1D0. Reading SPRN 0 returns 0.
- Write conflict: all ports write IVOR4 with 1/2/3 → IVOR4 reads 3.
- ITLB vector and handshake: IVPR=0xFFF0_0000, IVOR14=0x1E0, raise ITLB_req → excepCode=0x1E and intrEntryAddr=0xFFF0_01E0. Pulse ack → ITLB_ack high exactly one cycle.
- External masking: MSR=0x0000_0000 with DEV0_req=1 → excepCode stays 0. Set MSR=0x0000_C000 → excepCode=0x14. Pulse ack → DEV0_ack pulses once.
- Simultaneous requests: ITLB_req, SC_req and DEV1_req together → ITLB granted first, then SC, then DEV1. Each is acked in turn with no duplicate grants.
- Program error: progErr_req=1 with progErrCode=3'b010 → excepCode=0x16 and ESR reads 0x0400_0000 (bit 5 set). Assert rst during PEND → all outputs 0 and no progErr_ack.
